// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
// Shares one single-cycle-latency instruction memory between the fetch
// port (if_*) and a string-read port (str_*). Grants are combinational in
// the request cycle, the read data returns one cycle later on the port that
// owned the grant, and a starvation counter guarantees the string port a
// slot after STARVE_MAX consecutive contended fetch wins.
module imem_port_arbiter #(
   parameter int unsigned STARVE_MAX = 4,
   parameter logic [31:0] BASE_WORD  = 32'h00100000,
   parameter logic [31:0] LIMIT_WORD = 32'h00100100
) (
   input  logic        clk,
   input  logic        rst_n,

   // instruction fetch port
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   output logic        if_err,

   // string-read port
   input  logic        str_req,
   input  logic [31:0] str_addr,
   output logic        str_gnt,
   output logic        str_rvalid,
   output logic [31:0] str_rdata,
   output logic        str_err,

   // memory side
   output logic        mem_en,
   output logic [29:0] mem_addr,
   input  logic [31:0] mem_rdata,

   // statistics
   output logic [31:0] num_instr
);

   // The starvation counter is at least 3 bits wide and grows if STARVE_MAX
   // needs more.
   localparam int unsigned STARVE_CLOG = $clog2(STARVE_MAX + 1);
   localparam int unsigned STARVE_W    = (STARVE_CLOG > 3) ? STARVE_CLOG : 3;
   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

   // Which port the read currently in the response stage belongs to.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_STR  = 2'd2
   } owner_t;

   owner_t              owner_reg;
   logic                err_reg;
   logic [STARVE_W-1:0] starve_cnt_reg;
   logic [31:0]         num_instr_reg;

   logic                contended;
   logic                starve_hit;
   logic                if_win;
   logic                str_win;
   logic                any_gnt;
   logic [31:0]         sel_addr;
   logic [29:0]         sel_idx;
   logic                sel_legal;
   owner_t              owner_next;

   // ------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------
   assign contended  = if_req && str_req;
   assign starve_hit = (starve_cnt_reg == STARVE_LIM);

   // Nothing is granted while reset is held; the string port wins when it is
   // alone or when the fetch port has used up its run of contended wins.
   assign str_win = rst_n && str_req && (!if_req || starve_hit);
   assign if_win  = rst_n && if_req && !str_win;
   assign any_gnt = if_win || str_win;

   assign if_gnt  = if_win;
   assign str_gnt = str_win;

   // ------------------------------------------------------------------
   // Address selection and range check
   // ------------------------------------------------------------------
   // Byte offset bits are dropped: any byte address inside a word reads it.
   assign sel_addr = str_win ? str_addr : if_addr;
   assign sel_idx  = sel_addr[31:2];

   // Full 30-bit index, zero-extended, against the inclusive legal window.
   assign sel_legal = ({2'b00, sel_idx} >= BASE_WORD) &&
                      ({2'b00, sel_idx} <= LIMIT_WORD);

   // Out-of-range grants never touch memory; they only produce an error reply.
   assign mem_en   = any_gnt && sel_legal;
   assign mem_addr = sel_idx;

   // Owner of the next response stage, decided by this cycle's grant.
   always_comb begin
      owner_next = OWN_NONE;
      if (if_win) begin
         owner_next = OWN_IF;
      end else if (str_win) begin
         owner_next = OWN_STR;
      end
   end

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   // Response stage: remember who was granted and whether it was out of range.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_reg <= OWN_NONE;
         err_reg   <= 1'b0;
      end else begin
         owner_reg <= owner_next;
         err_reg   <= any_gnt && !sel_legal;
      end
   end

   // Starvation tracking: count contended fetch wins, clear on any string grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt_reg <= '0;
      end else if (str_win) begin
         starve_cnt_reg <= '0;
      end else if (contended && if_win && (starve_cnt_reg < STARVE_LIM)) begin
         starve_cnt_reg <= starve_cnt_reg + 1'b1;
      end
   end

   // Completed-fetch counter: steps on the edge that launches a legal fetch
   // response, so the new value is visible in the same cycle as if_rvalid.
   // Wraps naturally at 32 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         num_instr_reg <= '0;
      end else if (if_win && sel_legal) begin
         num_instr_reg <= num_instr_reg + 32'd1;
      end
   end

   assign num_instr = num_instr_reg;

   // ------------------------------------------------------------------
   // Response steering (index 0 = fetch port, 1 = string port)
   // ------------------------------------------------------------------
   logic [1:0]  port_valid;
   logic [1:0]  port_err;
   logic [31:0] port_rdata [2];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_resp
         localparam owner_t PORT_TAG = (gi == 0) ? OWN_IF : OWN_STR;
         // A port sees data only when it owns the response stage; an error
         // reply carries zero data.
         assign port_valid[gi] = (owner_reg == PORT_TAG);
         assign port_err[gi]   = port_valid[gi] && err_reg;
         assign port_rdata[gi] = (port_valid[gi] && !err_reg) ? mem_rdata : 32'h0;
      end
   endgenerate

   assign if_rvalid  = port_valid[0];
   assign if_err     = port_err[0];
   assign if_rdata   = port_rdata[0];
   assign str_rvalid = port_valid[1];
   assign str_err    = port_err[1];
   assign str_rdata  = port_rdata[1];

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter
// Directed stimulus with a per-cycle reference model of the arbiter and a
// small behavioural memory that returns a word one cycle after mem_en.
module tb_imem_port_arbiter;

   localparam int unsigned STARVE_MAX = 4;
   localparam logic [31:0] BASE_WORD  = 32'h00100000;
   localparam logic [31:0] LIMIT_WORD = 32'h00100100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = 32'h0;
   logic        str_req = 1'b0;
   logic [31:0] str_addr = 32'h0;
   logic [31:0] mem_rdata;

   logic        if_gnt, if_rvalid, if_err;
   logic [31:0] if_rdata;
   logic        str_gnt, str_rvalid, str_err;
   logic [31:0] str_rdata;
   logic        mem_en;
   logic [29:0] mem_addr;
   logic [31:0] num_instr;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // reference model state
   int          m_own   = 0;    // 0 none, 1 fetch, 2 string
   bit          m_err   = 1'b0;
   logic [31:0] m_data  = 32'h0;
   int          m_starve = 0;   // consecutive contended fetch wins since last string grant
   logic [31:0] m_count = 32'h0;

   imem_port_arbiter #(
      .STARVE_MAX (STARVE_MAX),
      .BASE_WORD  (BASE_WORD),
      .LIMIT_WORD (LIMIT_WORD)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_gnt     (if_gnt),
      .if_rvalid  (if_rvalid),
      .if_rdata   (if_rdata),
      .if_err     (if_err),
      .str_req    (str_req),
      .str_addr   (str_addr),
      .str_gnt    (str_gnt),
      .str_rvalid (str_rvalid),
      .str_rdata  (str_rdata),
      .str_err    (str_err),
      .mem_en     (mem_en),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .num_instr  (num_instr)
   );

   always #5 clk = ~clk;

   // Memory contents: one pinned word, everything else a hash of the index.
   function automatic logic [31:0] mem_word(input logic [29:0] a);
      if (a == 30'h00100002) return 32'h2008000A;
      return ({2'b00, a} * 32'h01000193) ^ 32'hA5A50000;
   endfunction

   // Memory returns data one cycle after mem_en; garbage otherwise so that
   // error replies must really be forced to zero.
   always @(posedge clk) begin
      mem_rdata <= mem_en ? mem_word(mem_addr) : 32'hBAD0BAD0;
   end

   task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_b(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Compare every DUT output with the model, then advance the model across
   // the coming clock edge.
   task automatic check_cycle();
      logic        e_ig, e_sg, legal, e_irv, e_srv;
      logic [31:0] a;
      logic [29:0] idx;
      if (!rst_n) begin
         chk_b("rst_if_gnt", if_gnt, 1'b0);
         chk_b("rst_str_gnt", str_gnt, 1'b0);
         chk_b("rst_mem_en", mem_en, 1'b0);
         chk_b("rst_if_rvalid", if_rvalid, 1'b0);
         chk_b("rst_str_rvalid", str_rvalid, 1'b0);
         chk_b("rst_if_err", if_err, 1'b0);
         chk_b("rst_str_err", str_err, 1'b0);
         chk_w("rst_if_rdata", if_rdata, 32'h0);
         chk_w("rst_str_rdata", str_rdata, 32'h0);
         chk_w("rst_num_instr", num_instr, 32'h0);
         m_own = 0; m_err = 1'b0; m_starve = 0; m_count = 32'h0;
         return;
      end
      e_sg  = str_req && (!if_req || (m_starve == int'(STARVE_MAX)));
      e_ig  = if_req && !e_sg;
      a     = e_sg ? str_addr : if_addr;
      idx   = a[31:2];
      legal = (e_ig || e_sg) && ({2'b00, idx} >= BASE_WORD) && ({2'b00, idx} <= LIMIT_WORD);
      chk_b("if_gnt", if_gnt, e_ig);
      chk_b("str_gnt", str_gnt, e_sg);
      chk_b("mem_en", mem_en, legal);
      if (legal) chk_w("mem_addr", 32'(mem_addr), 32'(idx));
      e_irv = (m_own == 1);
      e_srv = (m_own == 2);
      chk_b("if_rvalid", if_rvalid, e_irv);
      chk_b("if_err", if_err, e_irv && m_err);
      chk_w("if_rdata", if_rdata, (e_irv && !m_err) ? m_data : 32'h0);
      chk_b("str_rvalid", str_rvalid, e_srv);
      chk_b("str_err", str_err, e_srv && m_err);
      chk_w("str_rdata", str_rdata, (e_srv && !m_err) ? m_data : 32'h0);
      chk_w("num_instr", num_instr, m_count);
      // advance across the clock edge
      m_own  = e_ig ? 1 : (e_sg ? 2 : 0);
      m_err  = !legal;
      m_data = mem_word(idx);
      if (e_ig && legal) m_count = m_count + 32'd1;
      if (e_sg) m_starve = 0;
      else if (e_ig && str_req && m_starve < int'(STARVE_MAX)) m_starve++;
   endtask

   // One clock cycle: drive inputs just after the edge, check at the falling edge.
   task automatic step(input logic rst, input logic ir, input logic [31:0] ia,
                       input logic sr, input logic [31:0] sa);
      @(posedge clk);
      #1;
      rst_n = rst; if_req = ir; if_addr = ia; str_req = sr; str_addr = sa;
      @(negedge clk);
      cyc++;
      check_cycle();
      $display("cyc %0d rst_n=%b if_req=%b if_gnt=%b str_req=%b str_gnt=%b mem_en=%b if_rv=%b str_rv=%b num=%0d",
               cyc, rst_n, if_req, if_gnt, str_req, str_gnt, mem_en, if_rvalid, str_rvalid, num_instr);
   endtask

   task automatic idle();
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   logic [31:0] pat;

   initial begin
      // reset held with requests active: no grants, no memory strobe
      step(1'b0, 1'b1, 32'h00400000, 1'b1, 32'h00400004);
      step(1'b0, 1'b1, 32'h00400000, 1'b0, 32'h0);
      idle();
      chk_w("reset_num_instr", num_instr, 32'h0);
      chk_b("reset_if_rvalid", if_rvalid, 1'b0);

      // basic fetch with pinned memory word
      step(1'b1, 1'b1, 32'h00400008, 1'b0, 32'h0);
      chk_b("r32_if_gnt", if_gnt, 1'b1);
      chk_w("r32_mem_addr", 32'(mem_addr), 32'h00100002);
      idle();
      chk_b("r32_if_rvalid", if_rvalid, 1'b1);
      chk_w("r32_if_rdata", if_rdata, 32'h2008000A);
      chk_w("r32_num_instr", num_instr, 32'd1);

      // sustained contention: string forced in every fifth cycle
      pat = 32'h0;
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 1'b1, 32'h00400000 + 32'(4 * i), 1'b1, 32'h00400100 + 32'(4 * i));
         pat[i] = str_gnt;
      end
      chk_w("r33_str_pattern", pat, 32'h00000210);
      idle();

      // string read one word past the limit
      step(1'b1, 1'b0, 32'h0, 1'b1, 32'h00400404);
      chk_b("r34_str_gnt", str_gnt, 1'b1);
      chk_b("r34_mem_en", mem_en, 1'b0);
      idle();
      chk_b("r34_str_rvalid", str_rvalid, 1'b1);
      chk_b("r34_str_err", str_err, 1'b1);
      chk_w("r34_str_rdata", str_rdata, 32'h0);
      chk_w("r34_num_instr", num_instr, 32'd11);

      // range boundaries, byte offsets and high index bits
      step(1'b1, 1'b1, 32'h00400000, 1'b0, 32'h0);   // base
      step(1'b1, 1'b1, 32'h00400403, 1'b0, 32'h0);   // limit, offset 3
      step(1'b1, 1'b1, 32'h003FFFFC, 1'b0, 32'h0);   // base - 1
      step(1'b1, 1'b1, 32'h00400404, 1'b0, 32'h0);   // limit + 1
      chk_b("bound_low_err", if_err, 1'b1);
      step(1'b1, 1'b1, 32'hC0400000, 1'b0, 32'h0);   // high index bits set
      step(1'b1, 1'b0, 32'h0, 1'b1, 32'h00400001);   // string at base, offset 1
      step(1'b1, 1'b0, 32'h0, 1'b1, 32'h00400400);   // string at limit
      idle();
      chk_b("bound_str_limit_err", str_err, 1'b0);

      // alternating owners back to back
      step(1'b1, 1'b1, 32'h00400010, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0, 1'b1, 32'h00400020);
      step(1'b1, 1'b1, 32'h00400030, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0, 1'b1, 32'h00400040);
      step(1'b1, 1'b1, 32'h00400050, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0, 1'b1, 32'h00400060);
      chk_w("r35_if_rdata", if_rdata, mem_word(30'h00100014));
      idle();
      chk_w("r35_str_rdata", str_rdata, mem_word(30'h00100018));

      // reset one cycle after a contended fetch grant with starvation count high
      for (int i = 0; i < 4; i++)
         step(1'b1, 1'b1, 32'h00400100 + 32'(4 * i), 1'b1, 32'h00400200);
      chk_b("r36_if_gnt", if_gnt, 1'b1);
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      idle();
      chk_b("r36_if_rvalid", if_rvalid, 1'b0);
      chk_w("r36_num_instr", num_instr, 32'h0);
      pat = 32'h0;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b1, 32'h00400000, 1'b1, 32'h00400004);
         pat[i] = str_gnt;
      end
      chk_w("r36_str_pattern", pat, 32'h00000010);
      idle();

      // counter wrap from a preloaded all-ones value
      force dut.num_instr_reg = 32'hFFFFFFFF;
      #1;
      release dut.num_instr_reg;
      m_count = 32'hFFFFFFFF;
      idle();
      chk_w("r37_preload", num_instr, 32'hFFFFFFFF);
      step(1'b1, 1'b1, 32'h00400008, 1'b0, 32'h0);
      idle();
      chk_b("r37_if_rvalid", if_rvalid, 1'b1);
      chk_w("r37_num_wrap", num_instr, 32'h0);
      idle();
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
